// File: rtl/api_pll_cfg.sv
// api_pll_cfg: pops 104-bit PLL configuration words from the API FIFO and
// shifts each one MSB first to the miner PLL over a slow serial clock, then
// pulses a load strobe and counts the completed word.
module api_pll_cfg #(
    parameter int SCK_DIV  = 4,
    parameter int LOAD_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reg_pllf_rst,
    input  logic         reg_pllf_empty,
    input  logic [103:0] reg_pllf_dout,
    output logic         pllf_rd_en,
    output logic         pll_sck,
    output logic         pll_sdo,
    output logic         pll_load,
    output logic         pll_busy,
    output logic [7:0]   pll_cfg_cnt
);

    localparam logic [7:0] SCK_LAST  = 8'(SCK_DIV - 1);
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_LEN - 1);
    localparam logic [6:0] BIT_LAST  = 7'd103;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        SHIFT,
        LOAD
    } state_t;

    state_t       state, state_nxt;
    logic [103:0] shreg, shreg_nxt;
    logic [6:0]   bit_cnt, bit_cnt_nxt;
    logic [7:0]   phase_cnt, phase_cnt_nxt;
    logic         sck_nxt;
    logic         load_nxt;
    logic [7:0]   cnt_nxt;

    // The top of the shift register is the serial data flop itself, so sdo
    // is registered and moves only when the register shifts (start of low phase).
    assign pll_sdo    = shreg[103];
    assign pllf_rd_en = (state == POP);
    assign pll_busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath decode; an abort request overrides every state.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        phase_cnt_nxt = phase_cnt;
        sck_nxt       = pll_sck;
        load_nxt      = pll_load;
        cnt_nxt       = pll_cfg_cnt;

        if (reg_pllf_rst) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            sck_nxt   = 1'b0;
            load_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!reg_pllf_empty) begin
                        state_nxt = POP;
                    end
                end
                POP: begin
                    state_nxt = LATCH;
                end
                LATCH: begin
                    // FIFO data is valid now, one cycle after the pop strobe.
                    shreg_nxt     = reg_pllf_dout;
                    bit_cnt_nxt   = 7'd0;
                    phase_cnt_nxt = 8'd0;
                    sck_nxt       = 1'b0;
                    state_nxt     = SHIFT;
                end
                SHIFT: begin
                    // phase_cnt times one half-period; pll_sck tells which half.
                    if (phase_cnt == SCK_LAST) begin
                        phase_cnt_nxt = 8'd0;
                        if (!pll_sck) begin
                            sck_nxt = 1'b1;
                        end else if (bit_cnt == BIT_LAST) begin
                            sck_nxt   = 1'b0;
                            shreg_nxt = '0;
                            load_nxt  = 1'b1;
                            state_nxt = LOAD;
                        end else begin
                            sck_nxt     = 1'b0;
                            bit_cnt_nxt = bit_cnt + 7'd1;
                            shreg_nxt   = {shreg[102:0], 1'b0};
                        end
                    end else begin
                        phase_cnt_nxt = phase_cnt + 8'd1;
                    end
                end
                LOAD: begin
                    // phase_cnt was cleared on the last bit boundary and now times the strobe.
                    if (phase_cnt == LOAD_LAST) begin
                        load_nxt  = 1'b0;
                        cnt_nxt   = pll_cfg_cnt + 8'd1;
                        state_nxt = IDLE;
                    end else begin
                        phase_cnt_nxt = phase_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= 7'd0;
            phase_cnt   <= 8'd0;
            pll_sck     <= 1'b0;
            pll_load    <= 1'b0;
            pll_cfg_cnt <= 8'd0;
        end else begin
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            phase_cnt   <= phase_cnt_nxt;
            pll_sck     <= sck_nxt;
            pll_load    <= load_nxt;
            pll_cfg_cnt <= cnt_nxt;
        end
    end

endmodule
